// File: rtl/max_pooling_history_if.sv
// Stream bundle between a pixel producer and the max-pooling stage.
// The producer side (master) drives the frame start and the raster pixels;
// the pooling stage (slave) returns one pooled value plus argmax index per window.
interface max_pooling_history_if;
  logic               pool_start;
  logic               in_valid;
  logic signed [15:0] in_value;
  logic signed [15:0] pooled_value;
  logic        [1:0]  history_value;
  logic               out_valid;
  logic               pool_end;

  modport master (
    output pool_start,
    output in_valid,
    output in_value,
    input  pooled_value,
    input  history_value,
    input  out_valid,
    input  pool_end
  );

  modport slave (
    input  pool_start,
    input  in_valid,
    input  in_value,
    output pooled_value,
    output history_value,
    output out_valid,
    output pool_end
  );
endinterface

// File: rtl/max_pooling_history.sv
// Streaming 2x2 / stride-2 max pooling over a (2*SIZE)x(2*SIZE) signed map
// delivered in raster order. Each window produces its maximum together with
// a 2-bit position index (0 TL, 1 TR, 2 BL, 3 BR) so a later unpooling stage
// can put the maximum back where it came from.
//
// The window is reduced in two steps: horizontal pairs are reduced as the odd
// column arrives, top-row pair results are parked in a SIZE-entry row buffer,
// and the bottom-row pair is compared against the parked top pair. Every
// compare keeps the earlier scan position on a tie, which makes the earliest
// of several equal maxima win.
module max_pooling_history #(
  parameter int SIZE = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  max_pooling_history_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Counter width covers 0 .. 2*SIZE-1; buffer address covers 0 .. SIZE-1.
  localparam int CW = (2 * SIZE > 2) ? $clog2(2 * SIZE) : 1;
  localparam int BW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(2 * SIZE - 1);

  state_t             state_q;
  state_t             state_d;
  logic [CW-1:0]      col_q;
  logic [CW-1:0]      row_q;
  logic signed [15:0] even_q;

  // Top-row pair results, one per window column.
  logic signed [15:0] top_value [SIZE];
  logic               top_index [SIZE];

  logic               accept;
  logic               last_pixel;
  logic               window_done;
  logic [BW-1:0]      buf_addr;
  logic               odd_wins;
  logic signed [15:0] pair_value;
  logic               pair_index;
  logic               bottom_wins;
  logic signed [15:0] result_value;
  logic [1:0]         result_history;

  assign accept      = (state_q == RUN) && bus.in_valid;
  assign last_pixel  = accept && (col_q == LAST) && (row_q == LAST);
  assign window_done = accept && col_q[0] && row_q[0];
  assign buf_addr    = BW'(col_q >> 1);

  // Frame sequencing: wait for start, stream one frame, one-cycle DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; the last accepted pixel closes the frame.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.pool_start) state_d = RUN;
      RUN:     if (last_pixel)     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Raster position of the next pixel; cleared at frame end so each frame starts at (0,0).
  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else if (accept) begin
      if (col_q == LAST) begin
        col_q <= '0;
        row_q <= (row_q == LAST) ? '0 : row_q + CW'(1);
      end else begin
        col_q <= col_q + CW'(1);
      end
    end
  end

  // Hold the even-column pixel until its odd-column partner arrives.
  always_ff @(posedge clk) begin
    if (reset) begin
      even_q <= '0;
    end else if (accept && !col_q[0]) begin
      even_q <= bus.in_value;
    end
  end

  // Horizontal pair reduction and vertical top-vs-bottom reduction.
  always_comb begin
    odd_wins       = bus.in_value > even_q;
    pair_value     = odd_wins ? bus.in_value : even_q;
    pair_index     = odd_wins;
    bottom_wins    = pair_value > top_value[buf_addr];
    result_value   = bottom_wins ? pair_value : top_value[buf_addr];
    result_history = {bottom_wins, bottom_wins ? pair_index : top_index[buf_addr]};
  end

  // Park the top-row pair result until the bottom row of the window arrives.
  always_ff @(posedge clk) begin
    if (accept && col_q[0] && !row_q[0]) begin
      top_value[buf_addr] <= pair_value;
      top_index[buf_addr] <= pair_index;
    end
  end

  // Register window results; value and history hold between results.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.pooled_value  <= '0;
      bus.history_value <= '0;
      bus.out_valid     <= 1'b0;
      bus.pool_end      <= 1'b0;
    end else begin
      bus.out_valid <= window_done;
      bus.pool_end  <= last_pixel;
      if (window_done) begin
        bus.pooled_value  <= result_value;
        bus.history_value <= result_history;
      end
    end
  end

endmodule

// File: tb/tb_max_pooling_history.sv
// Directed bench for the max-pooling stage: a SIZE=2 instance for the
// hand-computed frames and a default SIZE=8 instance for a gapped full frame
// checked against a scan-order reference model.
module tb_max_pooling_history;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;

  max_pooling_history_if m2 ();
  max_pooling_history_if m8 ();

  max_pooling_history #(.SIZE(2)) dut2 (.clk(clk), .reset(reset), .bus(m2.slave));
  max_pooling_history             dut8 (.clk(clk), .reset(reset), .bus(m8.slave));

  always #5 clk = ~clk;

  // Cycle stamp used to measure result latency.
  always @(posedge clk) cyc <= cyc + 1;

  logic signed [15:0] q2_val [$];
  logic        [1:0]  q2_hist [$];
  logic               q2_end [$];
  int                 q2_cyc [$];
  int                 end2_cnt = 0;
  logic signed [15:0] q8_val [$];
  logic        [1:0]  q8_hist [$];
  int                 end8_cnt = 0;
  int                 px_cyc [16];

  // Collect results away from the active edge.
  always @(negedge clk) begin
    if (m2.out_valid) begin
      q2_val.push_back(m2.pooled_value);
      q2_hist.push_back(m2.history_value);
      q2_end.push_back(m2.pool_end);
      q2_cyc.push_back(cyc);
    end
    if (m2.pool_end) end2_cnt++;
    if (m8.out_valid) begin
      q8_val.push_back(m8.pooled_value);
      q8_hist.push_back(m8.history_value);
    end
    if (m8.pool_end) end8_cnt++;
  end

  task automatic clear2();
    q2_val.delete();
    q2_hist.delete();
    q2_end.delete();
    q2_cyc.delete();
    end2_cnt = 0;
  endtask

  // Start a SIZE=2 frame and stream 16 pixels back to back.
  task automatic run_frame2(input int px [16]);
    @(posedge clk); #1;
    m2.pool_start = 1'b1;
    @(posedge clk); #1;
    m2.pool_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m2.in_valid = 1'b1;
      m2.in_value = 16'(px[i]);
      px_cyc[i] = cyc;
      @(posedge clk); #1;
    end
    m2.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    m2.in_valid = 1'b1;
    m8.in_valid = 1'b1;
    m2.in_value = 16'h1234;
    m8.in_value = 16'h1234;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if (m2.pooled_value !== 16'h0) begin tests_failed++; $display("[TB] FAIL reset_pooled got %h want 0000", m2.pooled_value); end
    tests_run++;
    if (m2.history_value !== 2'd0) begin tests_failed++; $display("[TB] FAIL reset_history got %0d want 0", m2.history_value); end
    tests_run++;
    if (m2.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_out_valid got %b want 0", m2.out_valid); end
    tests_run++;
    if (m2.pool_end !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_pool_end got %b want 0", m2.pool_end); end
    tests_run++;
    if (m8.out_valid !== 1'b0 || m8.pool_end !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_size8 got valid=%b end=%b want 0/0", m8.out_valid, m8.pool_end);
    end
    reset = 1'b0;
    m2.in_valid = 1'b0;
    m8.in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_raster();
    int px [16];
    int exp_val [4] = '{6, 8, 14, 16};
    int exp_pos [4] = '{5, 7, 13, 15};
    for (int i = 0; i < 16; i++) px[i] = i + 1;
    clear2();
    run_frame2(px);
    tests_run++;
    if (q2_val.size() != 4) begin tests_failed++; $display("[TB] FAIL raster_count got %0d want 4", q2_val.size()); end
    for (int k = 0; k < 4 && k < q2_val.size(); k++) begin
      tests_run++;
      if (q2_val[k] !== 16'(exp_val[k]) || q2_hist[k] !== 2'd3) begin
        tests_failed++;
        $display("[TB] FAIL raster_result%0d got (%0d,%0d) want (%0d,3)", k, q2_val[k], q2_hist[k], exp_val[k]);
      end
      tests_run++;
      if (q2_cyc[k] !== px_cyc[exp_pos[k]] + 1) begin
        tests_failed++;
        $display("[TB] FAIL raster_latency%0d got cycle %0d want %0d", k, q2_cyc[k], px_cyc[exp_pos[k]] + 1);
      end
      tests_run++;
      if (q2_end[k] !== (k == 3)) begin
        tests_failed++;
        $display("[TB] FAIL raster_pool_end%0d got %b want %b", k, q2_end[k], (k == 3));
      end
    end
    tests_run++;
    if (end2_cnt != 1) begin tests_failed++; $display("[TB] FAIL raster_end_count got %0d want 1", end2_cnt); end
  endtask

  task automatic test_ties();
    int px [16] = '{5, 9, 0, 0, -3, 9, 0, 0, 1, 2, -100, -200, 7, 3, -300, -400};
    int exp_val [4] = '{9, 0, 7, -100};
    int exp_hist [4] = '{1, 0, 2, 0};
    clear2();
    run_frame2(px);
    tests_run++;
    if (q2_val.size() != 4) begin tests_failed++; $display("[TB] FAIL ties_count got %0d want 4", q2_val.size()); end
    for (int k = 0; k < 4 && k < q2_val.size(); k++) begin
      tests_run++;
      if (q2_val[k] !== 16'(exp_val[k]) || q2_hist[k] !== 2'(exp_hist[k])) begin
        tests_failed++;
        $display("[TB] FAIL ties_window%0d got (%h,%0d) want (%h,%0d)", k, q2_val[k], q2_hist[k], 16'(exp_val[k]), exp_hist[k]);
      end
    end
  endtask

  task automatic test_signed();
    int px [16] = '{-5, -2, -32768, 32767, -7, -1, 0, 32767, 3, 1, -1, -1, 2, 0, -1, 4};
    int exp_val [4] = '{-1, 32767, 3, 4};
    int exp_hist [4] = '{3, 1, 0, 3};
    clear2();
    run_frame2(px);
    tests_run++;
    if (q2_val.size() != 4) begin tests_failed++; $display("[TB] FAIL signed_count got %0d want 4", q2_val.size()); end
    for (int k = 0; k < 4 && k < q2_val.size(); k++) begin
      tests_run++;
      if (q2_val[k] !== 16'(exp_val[k]) || q2_hist[k] !== 2'(exp_hist[k])) begin
        tests_failed++;
        $display("[TB] FAIL signed_window%0d got (%h,%0d) want (%h,%0d)", k, q2_val[k], q2_hist[k], 16'(exp_val[k]), exp_hist[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int exp_val [8] = '{6, 8, 14, 16, 16, 14, 8, 6};
    clear2();
    @(posedge clk); #1;
    m2.pool_start = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++) begin
      m2.in_valid = 1'b1;
      m2.in_value = 16'(i + 1);
      @(posedge clk); #1;
    end
    // Valid junk during DONE and the idle cycle must be ignored.
    repeat (2) begin
      m2.in_valid = 1'b1;
      m2.in_value = 16'sd1000;
      @(posedge clk); #1;
    end
    m2.pool_start = 1'b0;
    for (int i = 0; i < 16; i++) begin
      m2.in_valid = 1'b1;
      m2.in_value = 16'(16 - i);
      @(posedge clk); #1;
    end
    m2.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q2_val.size() != 8) begin tests_failed++; $display("[TB] FAIL b2b_count got %0d want 8", q2_val.size()); end
    for (int k = 0; k < 8 && k < q2_val.size(); k++) begin
      tests_run++;
      if (q2_val[k] !== 16'(exp_val[k]) || q2_hist[k] !== ((k < 4) ? 2'd3 : 2'd0) || q2_end[k] !== (k == 3 || k == 7)) begin
        tests_failed++;
        $display("[TB] FAIL b2b_result%0d got (%0d,%0d,end=%b) want (%0d,%0d,end=%b)", k, q2_val[k], q2_hist[k], q2_end[k],
                 exp_val[k], (k < 4) ? 3 : 0, (k == 3 || k == 7));
      end
    end
    tests_run++;
    if (end2_cnt != 2) begin tests_failed++; $display("[TB] FAIL b2b_end_count got %0d want 2", end2_cnt); end
  endtask

  task automatic test_gapped_size8();
    logic signed [15:0] img [16][16];
    logic signed [15:0] best;
    logic signed [15:0] v;
    int bi;
    int k;
    for (int r = 0; r < 16; r++)
      for (int c = 0; c < 16; c++)
        img[r][c] = 16'(int'($urandom_range(0, 20)) - 10);
    img[0][0] = 16'h8000;
    img[3][5] = 16'h7FFF;
    q8_val.delete();
    q8_hist.delete();
    end8_cnt = 0;
    @(posedge clk); #1;
    m8.pool_start = 1'b1;
    @(posedge clk); #1;
    m8.pool_start = 1'b0;
    k = 0;
    while (k < 256) begin
      if ($urandom_range(0, 3) != 0) begin
        m8.in_valid = 1'b1;
        m8.in_value = img[k / 16][k % 16];
        k++;
      end else begin
        m8.in_valid = 1'b0;
        m8.in_value = 16'h7777;
      end
      @(posedge clk); #1;
    end
    m8.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests_run++;
    if (q8_val.size() != 64) begin tests_failed++; $display("[TB] FAIL size8_count got %0d want 64", q8_val.size()); end
    tests_run++;
    if (end8_cnt != 1) begin tests_failed++; $display("[TB] FAIL size8_end_count got %0d want 1", end8_cnt); end
    for (int w = 0; w < 64 && w < q8_val.size(); w++) begin
      best = img[2 * (w / 8)][2 * (w % 8)];
      bi = 0;
      for (int p = 1; p < 4; p++) begin
        v = img[2 * (w / 8) + p / 2][2 * (w % 8) + p % 2];
        if (v > best) begin
          best = v;
          bi = p;
        end
      end
      tests_run++;
      if (q8_val[w] !== best || q8_hist[w] !== 2'(bi)) begin
        tests_failed++;
        $display("[TB] FAIL size8_window%0d got (%h,%0d) want (%h,%0d)", w, q8_val[w], q8_hist[w], best, bi);
      end
    end
  endtask

  task automatic test_reset_midframe();
    int px [16];
    clear2();
    @(posedge clk); #1;
    m2.pool_start = 1'b1;
    @(posedge clk); #1;
    m2.pool_start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      m2.in_valid = 1'b1;
      m2.in_value = 16'(100 + i);
      @(posedge clk); #1;
    end
    m2.in_valid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    tests_run++;
    if (m2.out_valid !== 1'b0 || m2.pooled_value !== 16'h0 || m2.history_value !== 2'd0) begin
      tests_failed++;
      $display("[TB] FAIL midreset_outputs got valid=%b value=%h hist=%0d want 0/0000/0", m2.out_valid, m2.pooled_value, m2.history_value);
    end
    tests_run++;
    if (end2_cnt != 0) begin tests_failed++; $display("[TB] FAIL midreset_no_end got %0d want 0", end2_cnt); end
    repeat (2) @(posedge clk);
    #1;
    clear2();
    for (int i = 0; i < 16; i++) px[i] = i + 1;
    run_frame2(px);
    tests_run++;
    if (q2_val.size() != 4) begin tests_failed++; $display("[TB] FAIL midreset_count got %0d want 4", q2_val.size()); end
    for (int k = 0; k < 4 && k < q2_val.size(); k++) begin
      tests_run++;
      if (q2_val[k] !== 16'((k < 2) ? 6 + 2 * k : 14 + 2 * (k - 2)) || q2_hist[k] !== 2'd3) begin
        tests_failed++;
        $display("[TB] FAIL midreset_result%0d got (%0d,%0d) want (%0d,3)", k, q2_val[k], q2_hist[k],
                 (k < 2) ? 6 + 2 * k : 14 + 2 * (k - 2));
      end
    end
    tests_run++;
    if (end2_cnt != 1) begin tests_failed++; $display("[TB] FAIL midreset_end_count got %0d want 1", end2_cnt); end
  endtask

  initial begin
    m2.pool_start = 1'b0;
    m2.in_valid = 1'b0;
    m2.in_value = '0;
    m8.pool_start = 1'b0;
    m8.in_valid = 1'b0;
    m8.in_value = '0;
    test_reset();
    test_raster();
    test_ties();
    test_signed();
    test_back_to_back();
    test_gapped_size8();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/max_pooling_history.md
# max_pooling_history

Streaming 2x2/stride-2 max-pooling stage that consumes a (2·SIZE)x(2·SIZE) signed feature map in raster order and emits one pooled value per window, together with a 2-bit history index recording which window position held the maximum. It is the forward-path counterpart of the unpooling stage: its `pooled_value`/`history_value` stream, in pooled raster order, is exactly what unpooling consumes to rebuild the full map.

## Interface

- `SIZE`, default 8, pooled map width/height; input map is 2·SIZE x 2·SIZE (SIZE ≥ 1, power of two not required).
- `clk`  in  1  clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high reset.
- `pool_start`  in  1  level; sampled in IDLE, high starts a frame.
- `in_valid`  in  1  `in_value` carries the next raster pixel this cycle.
- `in_value`  in  16  signed input pixel.
- `pooled_value`  out  16  signed window maximum (registered).
- `history_value`  out  2  argmax position: 0 top-left, 1 top-right, 2 bottom-left, 3 bottom-right.
- `out_valid`  out  1  one-cycle pulse qualifying `pooled_value`/`history_value`.
- `pool_end`  out  1  one-cycle pulse coincident with the frame's last `out_valid`.

## Operation

- Reset: clock and reset ports as above; polarity/synchronicity fixed. All outputs 0, state IDLE, counters 0, row buffer contents don't-care.
- States: IDLE -> RUN when `pool_start`=1; RUN -> DONE when the last pixel (row 2·SIZE-1, col 2·SIZE-1) is accepted; DONE -> IDLE unconditionally after one cycle. `pool_start` held high causes back-to-back frames (one idle cycle between).
- Pixels accepted only in RUN with `in_valid`=1; `in_valid` ignored in IDLE/DONE. No backpressure on either side.
- Counters `col`, `row`, width $clog2(2·SIZE) (min 1); `col` wraps at 2·SIZE-1 and increments `row`.
- Pair stage: even column pixel held in a register; on the odd column, pair max = odd pixel if strictly greater than held, else held; pair index bit = 1 if odd chosen.
- Even row: pair result (16-bit value + 1-bit index) written to row buffer entry `col>>1` (SIZE entries).
- Odd row: bottom pair compared with buffered top pair; bottom wins only if strictly greater. history = {bottom_won, pair_index_of_winner}. Result registered to outputs with `out_valid`=1.
- Tie rule: earliest position in scan order (0<1<2<3) wins; all compares are signed 16-bit.
- Output order: pooled raster order, SIZE·SIZE results per frame.
- `pooled_value`/`history_value` hold last result when `out_valid`=0.

## Timing

- Latency: `out_valid` asserts the cycle after the bottom-right pixel of a window is accepted (1 cycle).
- Gaps in `in_valid` stretch the frame; no result lost or duplicated.
- `pool_end` asserts in DONE, same cycle as the final `out_valid`; exactly once per frame.
- First pixel may be presented the cycle after `pool_start` is sampled high in IDLE (cycle state is RUN).
- `reset` mid-frame: next edge returns to IDLE, outputs 0, counters 0; partial frame discarded, no `pool_end`.
- Throughput: one pixel per cycle sustained; max one result per two cycles.

## Test plan

- Reset: hold `reset` 2 cycles with `in_valid`=1 -> `pooled_value`=0, `history_value`=0, `out_valid`=0, `pool_end`=0.
- SIZE=2, pixels 1..16 raster, `in_valid` continuous -> outputs (6,3),(8,3),(14,3),(16,3), each 1 cycle after pixels 6/8/14/16; `pool_end` with the 4th.
- SIZE=2 ties/positions: windows {5,9 / -3,9} -> (9,1); {0,0 / 0,0} -> (0,0); {1,2 / 7,3} -> (7,2); {-100,-200 / -300,-400} -> (-100 = 0xFF9C, 0).
- Signed: window {-5,-2 / -7,-1} -> (0xFFFF, 3); window {-32768, 32767 / 0, 32767} -> (32767, 1).
- Default SIZE=8, 256 pixels with `in_valid` toggling pseudo-randomly -> 64 results matching a software model, `pool_end` exactly once; feeding the stream into unpooling restores maxima at original positions.
- Reset after 10 accepted pixels, then a full SIZE=2 frame of 1..16 -> no output from the aborted frame; new frame gives the four (x,3) results above.
